// File: rtl/alu_arbiter.sv
// alu_arbiter: shares a single ALU between two requesters under round-robin arbitration.
// At most one operation is issued per cycle. Each requester owns a one-entry registered
// response slot that holds the result and the {Z,N,C,V} flags. An accepted operation's
// response is visible one cycle after the accept.
//
// Ports:
//   clk, rst                     clock; synchronous active-high reset
//   reqN_valid/ready             request handshake; ready is combinational and equals the grant
//   reqN_a, reqN_b, reqN_op      operands and opcode
//   respN_valid/ready            response handshake for slot N
//   respN_result, respN_flags    registered result and {Z,N,C,V}
//   op_count                     accepted operations, wraps modulo 2^CNT_W
//   busy                         either response slot holds a result
//
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
// All other opcodes are undefined and produce result 0 with flags 1000.
module alu_arbiter #(
  parameter int unsigned RR_INIT = 0,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [31:0]      resp0_result,
  output logic [3:0]       resp0_flags,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [31:0]      resp1_result,
  output logic [3:0]       resp1_flags,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpSlt  = 4'd8;
  localparam logic [3:0] OpSltu = 4'd9;

  // The reset value of last_grant is the loser, so the first contended cycle goes to RR_INIT.
  localparam logic LastGrantInit = (RR_INIT == 0) ? 1'b1 : 1'b0;

  logic             resp0_valid_q, resp1_valid_q;
  logic [31:0]      resp0_result_q, resp1_result_q;
  logic [3:0]       resp0_flags_q, resp1_flags_q;
  logic [CNT_W-1:0] op_count_q;
  logic             last_grant_q;

  logic free0, free1, elig0, elig1, grant0, grant1;

  // A slot being drained this cycle can be refilled in the same cycle.
  assign free0 = ~resp0_valid_q | resp0_ready;
  assign free1 = ~resp1_valid_q | resp1_ready;
  assign elig0 = req0_valid & free0;
  assign elig1 = req1_valid & free1;

  // On contention, the requester that did not win last time takes the grant.
  assign grant0 = elig0 & (~elig1 | last_grant_q);
  assign grant1 = elig1 & (~elig0 | ~last_grant_q);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Operand mux; defaults to requester 0 when idle (output unused then).
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  assign alu_a  = grant1 ? req1_a  : req0_a;
  assign alu_b  = grant1 ? req1_b  : req0_b;
  assign alu_op = grant1 ? req1_op : req0_op;

  logic [31:0] alu_res;
  logic        alu_c, alu_v;
  logic [32:0] alu_wide;
  logic [3:0]  alu_flags;

  always_comb begin
    alu_res  = 32'd0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_wide = 33'd0;
    unique case (alu_op)
      OpAdd: begin
        alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res  = alu_wide[31:0];
        alu_c    = alu_wide[32];
        alu_v    = (alu_a[31] == alu_b[31]) & (alu_res[31] != alu_a[31]);
      end
      OpSub: begin
        alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
        alu_res  = alu_wide[31:0];
        // Carry reports "no borrow".
        alu_c    = ~alu_wide[32];
        alu_v    = (alu_a[31] != alu_b[31]) & (alu_res[31] != alu_a[31]);
      end
      OpAnd:  alu_res = alu_a & alu_b;
      OpOr:   alu_res = alu_a | alu_b;
      OpXor:  alu_res = alu_a ^ alu_b;
      OpSll:  alu_res = alu_a << alu_b[4:0];
      OpSrl:  alu_res = alu_a >> alu_b[4:0];
      OpSra:  alu_res = $signed(alu_a) >>> alu_b[4:0];
      OpSlt:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      OpSltu: alu_res = {31'd0, alu_a < alu_b};
      default: alu_res = 32'd0;
    endcase
  end

  assign alu_flags = {alu_res == 32'd0, alu_res[31], alu_c, alu_v};

  always_ff @(posedge clk) begin
    if (rst) begin
      resp0_valid_q  <= 1'b0;
      resp1_valid_q  <= 1'b0;
      resp0_result_q <= 32'd0;
      resp1_result_q <= 32'd0;
      resp0_flags_q  <= 4'd0;
      resp1_flags_q  <= 4'd0;
      op_count_q     <= '0;
      last_grant_q   <= LastGrantInit;
    end else begin
      if (grant0) begin
        resp0_valid_q  <= 1'b1;
        resp0_result_q <= alu_res;
        resp0_flags_q  <= alu_flags;
      end else if (resp0_ready) begin
        resp0_valid_q <= 1'b0;
      end

      if (grant1) begin
        resp1_valid_q  <= 1'b1;
        resp1_result_q <= alu_res;
        resp1_flags_q  <= alu_flags;
      end else if (resp1_ready) begin
        resp1_valid_q <= 1'b0;
      end

      if (grant0 | grant1) begin
        last_grant_q <= grant1;
        op_count_q   <= op_count_q + CNT_W'(1);
      end
    end
  end

  assign resp0_valid  = resp0_valid_q;
  assign resp1_valid  = resp1_valid_q;
  assign resp0_result = resp0_result_q;
  assign resp1_result = resp1_result_q;
  assign resp0_flags  = resp0_flags_q;
  assign resp1_flags  = resp1_flags_q;
  assign op_count     = op_count_q;
  assign busy         = resp0_valid_q | resp1_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed steps with a per-slot scoreboard queue.
module tb_alu_arbiter;

  localparam int unsigned CW = 4;

  logic          clk, rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]   req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_op, req1_op;
  logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0]   resp0_result, resp1_result;
  logic [3:0]    resp0_flags, resp1_flags;
  logic [CW-1:0] op_count;
  logic          busy;

  alu_arbiter #(.RR_INIT(0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .resp0_flags(resp0_flags),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .resp1_flags(resp1_flags),
    .op_count(op_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic          m_v0, m_v1, m_last;
  logic [CW-1:0] m_cnt;
  logic [35:0]   m_h0, m_h1;  // {flags, result} currently held in each slot
  logic [35:0]   q0[$];
  logic [35:0]   q1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    r = 32'd0; c = 1'b0; v = 1'b0; w = 33'd0;
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
        v = (a[31] & b[31] & ~r[31]) | (~a[31] & ~b[31] & r[31]);
      end
      4'd1: begin
        r = a - b; c = (a >= b); v = (a[31] ^ b[31]) & (a[31] ^ r[31]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $signed(a) >>> b[4:0];
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r[31], c, v, r};
  endfunction

  task automatic step(input logic r,
                      input logic v0, input logic [3:0] o0, input logic [31:0] a0,
                      input logic [31:0] b0,
                      input logic v1, input logic [3:0] o1, input logic [31:0] a1,
                      input logic [31:0] b1,
                      input logic rr0, input logic rr1);
    logic e0, e1, g0, g1;
    rst = r;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    resp0_ready = rr0; resp1_ready = rr1;
    #1;
    e0 = v0 & (~m_v0 | rr0);
    e1 = v1 & (~m_v1 | rr1);
    g0 = e0 & (~e1 | m_last);
    g1 = e1 & (~e0 | ~m_last);
    chk("req0_ready", 64'(req0_ready), 64'(g0));
    chk("req1_ready", 64'(req1_ready), 64'(g1));
    if (!r) begin
      if (g0) q0.push_back(alu_model(o0, a0, b0));
      if (g1) q1.push_back(alu_model(o1, a1, b1));
    end
    @(posedge clk);
    if (r) begin
      m_v0 = 1'b0; m_v1 = 1'b0; m_cnt = '0; m_last = 1'b1;
      m_h0 = '0; m_h1 = '0;
      q0.delete(); q1.delete();
    end else begin
      if (g0) m_v0 = 1'b1; else if (rr0) m_v0 = 1'b0;
      if (g1) m_v1 = 1'b1; else if (rr1) m_v1 = 1'b0;
      if (g0 | g1) begin
        m_last = g1;
        m_cnt  = m_cnt + CW'(1);
      end
    end
    #1;
    if (!r && g0) begin
      if (q0.size() == 0) chk("q0_underflow", 64'd1, 64'd0);
      else m_h0 = q0.pop_front();
    end
    if (!r && g1) begin
      if (q1.size() == 0) chk("q1_underflow", 64'd1, 64'd0);
      else m_h1 = q1.pop_front();
    end
    chk("resp0_valid", 64'(resp0_valid), 64'(m_v0));
    chk("resp1_valid", 64'(resp1_valid), 64'(m_v1));
    chk("resp0_result", 64'(resp0_result), 64'(m_h0[31:0]));
    chk("resp0_flags", 64'(resp0_flags), 64'(m_h0[35:32]));
    chk("resp1_result", 64'(resp1_result), 64'(m_h1[31:0]));
    chk("resp1_flags", 64'(resp1_flags), 64'(m_h1[35:32]));
    chk("op_count", 64'(op_count), 64'(m_cnt));
    chk("busy", 64'(busy), 64'(m_v0 | m_v1));
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    m_v0 = 1'b0; m_v1 = 1'b0; m_last = 1'b1; m_cnt = '0; m_h0 = '0; m_h1 = '0;
    #2;

    // Reset, then check reset state with nothing requested.
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // ADD carry-out to zero.
    step(1'b0, 1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("tp_add_result", 64'(resp0_result), 64'h0);
    chk("tp_add_flags", 64'(resp0_flags), 64'b1010);
    chk("tp_add_count", 64'(op_count), 64'd1);

    // SUB with signed overflow, then SLT.
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd1, 32'h8000_0000, 32'd1, 1'b1, 1'b1);
    chk("tp_sub_result", 64'(resp1_result), 64'h7FFF_FFFF);
    chk("tp_sub_flags", 64'(resp1_flags), 64'b0011);
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd8, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
    chk("tp_slt_result", 64'(resp1_result), 64'd1);
    chk("tp_slt_flags", 64'(resp1_flags), 64'b0000);

    // Continuous contention: grants alternate, count wraps through CW bits.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom,
           1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'b1, 1'b1);
    end

    // Stall slot 0: fill it, hold resp0_ready low while requester 1 keeps going.
    step(1'b0, 1'b1, 4'd4, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'd0, 32'd5, 32'd6, 1'b1, 4'($urandom_range(0, 9)), $urandom, $urandom,
           1'b0, 1'b1);
    end
    // Releasing resp0_ready lets requester 0 in that same cycle.
    step(1'b0, 1'b1, 4'd7, 32'h8000_0000, 32'd4, 1'b1, 4'd2, 32'hFF, 32'h0F, 1'b1, 1'b1);

    // Undefined opcode.
    step(1'b0, 1'b1, 4'hF, 32'h1, 32'h2, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("tp_undef_result", 64'(resp0_result), 64'h0);
    chk("tp_undef_flags", 64'(resp0_flags), 64'b1000);

    // Fill both slots, then reset with them outstanding.
    step(1'b0, 1'b1, 4'd3, 32'hA, 32'h5, 1'b1, 4'd9, 32'd1, 32'd2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd3, 32'hA, 32'h5, 1'b1, 4'd9, 32'd1, 32'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd0, 32'd1, 32'd1, 1'b1, 4'd0, 32'd1, 32'd1, 1'b0, 1'b0);
    chk("tp_rst_valid0", 64'(resp0_valid), 64'd0);
    chk("tp_rst_valid1", 64'(resp1_valid), 64'd0);
    chk("tp_rst_count", 64'(op_count), 64'd0);
    chk("tp_rst_busy", 64'(busy), 64'd0);

    // First contended cycle after release goes to requester 0.
    step(1'b0, 1'b1, 4'd0, 32'd3, 32'd4, 1'b1, 4'd1, 32'd3, 32'd4, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
